// File: rtl/write_buffer.sv
// Posted-store write buffer: a circular FIFO of {addr, data, sel} drained one entry at a
// time to an AXI write adapter, with a word-granular load-hazard check against pending stores.
module write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data,
  input  logic [3:0]  cpu_sel,
  output logic        cpu_write_ready,
  output logic        full,
  output logic        empty,
  input  logic        rd_re,
  input  logic [31:0] rd_addr,
  output logic        rd_hit,
  output logic        we,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic [3:0]  select,
  input  logic        mem_write_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, next_state;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop, issue;
  logic            hit_any;
  logic [PW-1:0]   offset;
  logic            unused_rd_lsb;

  logic [31:0]     mem_addr [DEPTH];
  logic [31:0]     mem_data [DEPTH];
  logic [3:0]      mem_sel  [DEPTH];

  assign push            = cpu_we & ~full;
  assign cpu_write_ready = push;
  assign full            = (count == CW'(DEPTH));
  assign we              = (state == BUSY);
  assign empty           = (count == '0) & ~we;
  assign unused_rd_lsb   = ^rd_addr[1:0];

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          issue      = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (mem_write_done) begin
          pop        = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity comes only from rd_ptr/count.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_addr[wr_ptr] <= cpu_addr;
      mem_data[wr_ptr] <= cpu_data;
      mem_sel[wr_ptr]  <= cpu_sel;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      address <= '0;
      data    <= '0;
      select  <= '0;
    end else if (issue) begin
      address <= mem_addr[rd_ptr];
      data    <= mem_data[rd_ptr];
      select  <= mem_sel[rd_ptr];
    end
  end

  // The in-flight entry sits at rd_ptr and is still counted, so it is covered here too.
  always_comb begin
    hit_any = 1'b0;
    offset  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr;
      if (({1'b0, offset} < count) && (mem_addr[i][31:2] == rd_addr[31:2]))
        hit_any = 1'b1;
    end
  end

  assign rd_hit = rd_re & hit_any;

endmodule

// File: tb/tb_write_buffer.sv
// Directed and scoreboarded checks of write_buffer: reset, single store, fill/backpressure,
// push/pop with pointer wrap, load hazard, reset mid-write and random done latency.
module tb_write_buffer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cpu_we;
  logic [31:0] cpu_addr, cpu_data;
  logic [3:0]  cpu_sel;
  logic        cpu_write_ready, full, empty;
  logic        rd_re;
  logic [31:0] rd_addr;
  logic        rd_hit;
  logic        we;
  logic [31:0] address, data;
  logic [3:0]  select;
  logic        mem_write_done;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  write_buffer #(.DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_sel(cpu_sel),
    .cpu_write_ready(cpu_write_ready), .full(full), .empty(empty),
    .rd_re(rd_re), .rd_addr(rd_addr), .rd_hit(rd_hit),
    .we(we), .address(address), .data(data), .select(select),
    .mem_write_done(mem_write_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cpu_we = 1'b1; cpu_addr = a; cpu_data = d; cpu_sel = s;
    #1 check("push_ready", cpu_write_ready, 1);
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic wait_we(input string tag);
    int n = 0;
    while (we !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, we, 1);
  endtask

  task automatic drain_one(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wait_we("drain_we");
    check("drain_addr", address, a);
    check("drain_data", data, d);
    check("drain_sel", select, s);
    mem_write_done = 1'b1;
    tick();
    mem_write_done = 1'b0;
  endtask

  logic [31:0] qa[$], qd[$];
  logic [3:0]  qs[$];

  initial begin
    int sent, issued, lat, cyc;
    logic prev_we, prev_done, pend;
    logic [31:0] ra, rdd, cur_addr;
    logic [3:0]  rs;

    aresetn = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0; cpu_sel = '0;
    rd_re = 1'b0; rd_addr = '0; mem_write_done = 1'b0;
    repeat (2) tick();
    check("rst_we", we, 0);
    check("rst_address", address, 0);
    check("rst_data", data, 0);
    check("rst_select", select, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    aresetn = 1'b1;
    tick();

    // single store
    cpu_we = 1'b1; cpu_addr = 32'h8000_0010; cpu_data = 32'hDEAD_BEEF; cpu_sel = 4'hF;
    #1 check("single_ready", cpu_write_ready, 1);
    tick();
    cpu_we = 1'b0;
    check("single_no_bypass", we, 0);
    check("single_not_empty", empty, 0);
    tick();
    check("single_we", we, 1);
    check("single_addr", address, 32'h8000_0010);
    check("single_data", data, 32'hDEAD_BEEF);
    check("single_sel", select, 4'hF);
    repeat (3) tick();
    check("single_we_held", we, 1);
    check("single_addr_held", address, 32'h8000_0010);
    mem_write_done = 1'b1;
    tick();
    mem_write_done = 1'b0;
    check("single_we_clr", we, 0);
    check("single_empty", empty, 1);

    // fill with done withheld
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 32'h5555_0000 | 32'(i), 4'hF);
    check("fill_full", full, 1);
    cpu_we = 1'b1; cpu_addr = 32'h110; cpu_data = 32'h5555_0004; cpu_sel = 4'hF;
    #1 check("fill_5th_blocked", cpu_write_ready, 0);
    tick();
    check("fill_still_full", full, 1);
    check("fill_still_blocked", cpu_write_ready, 0);
    check("fill_first_we", we, 1);
    check("fill_first_addr", address, 32'h100);
    mem_write_done = 1'b1;
    #1 check("fill_blocked_on_done", cpu_write_ready, 0);
    tick();
    mem_write_done = 1'b0;
    check("fill_not_full", full, 0);
    check("fill_5th_ready", cpu_write_ready, 1);
    tick();
    cpu_we = 1'b0;
    for (int i = 1; i < 5; i++) drain_one(32'h100 + 32'(4 * i), 32'h5555_0000 | 32'(i), 4'hF);
    tick();
    check("fill_empty", empty, 1);

    // simultaneous push and pop, 8 times across pointer wrap
    qa.delete(); qd.delete(); qs.delete();
    push(32'h400, 32'hA000_0000, 4'h3); qa.push_back(32'h400); qd.push_back(32'hA000_0000); qs.push_back(4'h3);
    push(32'h404, 32'hA000_0001, 4'hC); qa.push_back(32'h404); qd.push_back(32'hA000_0001); qs.push_back(4'hC);
    for (int k = 0; k < 8; k++) begin
      wait_we("pp_we");
      check("pp_addr", address, qa[0]);
      check("pp_data", data, qd[0]);
      cpu_we = 1'b1; cpu_addr = 32'h500 + 32'(4 * k); cpu_data = 32'hB000_0000 | 32'(k);
      cpu_sel = 4'(k + 1); mem_write_done = 1'b1;
      #1 check("pp_ready", cpu_write_ready, 1);
      tick();
      cpu_we = 1'b0; mem_write_done = 1'b0;
      check("pp_count", 32'(dut.count), 2);
      void'(qa.pop_front()); void'(qd.pop_front()); void'(qs.pop_front());
      qa.push_back(32'h500 + 32'(4 * k)); qd.push_back(32'hB000_0000 | 32'(k)); qs.push_back(4'(k + 1));
    end
    drain_one(qa[0], qd[0], qs[0]);
    drain_one(qa[1], qd[1], qs[1]);
    tick();
    check("pp_empty", empty, 1);

    // load hazard
    push(32'h200, 32'h11, 4'h1);
    rd_re = 1'b1; rd_addr = 32'h203;
    #1 check("hz_hit_203", rd_hit, 1);
    rd_addr = 32'h204;
    #1 check("hz_miss_204", rd_hit, 0);
    rd_addr = 32'h1FF;
    #1 check("hz_miss_1ff", rd_hit, 0);
    tick();
    check("hz_inflight_we", we, 1);
    rd_addr = 32'h200;
    #1 check("hz_hit_inflight", rd_hit, 1);
    rd_re = 1'b0;
    #1 check("hz_no_re", rd_hit, 0);
    mem_write_done = 1'b1;
    tick();
    mem_write_done = 1'b0;
    rd_re = 1'b1; rd_addr = 32'h203;
    #1 check("hz_after_done", rd_hit, 0);
    rd_re = 1'b0;
    tick();

    // reset during a write
    push(32'h300, 32'h1, 4'hF);
    push(32'h304, 32'h2, 4'hF);
    push(32'h308, 32'h3, 4'hF);
    check("rm_we_before", we, 1);
    aresetn = 1'b0;
    #1 check("rm_we_async", we, 0);
    check("rm_empty", empty, 1);
    check("rm_full", full, 0);
    check("rm_address", address, 0);
    tick();
    aresetn = 1'b1;
    tick();
    mem_write_done = 1'b1;
    tick();
    mem_write_done = 1'b0;
    check("rm_stray_we", we, 0);
    repeat (3) tick();
    check("rm_we_quiet", we, 0);
    check("rm_empty_after", empty, 1);
    check("rm_count", 32'(dut.count), 0);

    // random stores against a scoreboard with random done latency
    qa.delete(); qd.delete(); qs.delete();
    sent = 0; issued = 0; lat = 0; cyc = 0;
    prev_we = 1'b0; prev_done = 1'b0; pend = 1'b0;
    ra = '0; rdd = '0; rs = '0; cur_addr = '0;
    while ((sent < 40 || qa.size() > 0 || we) && cyc < 3000) begin
      if (prev_we && !prev_done) check("rnd_we_hold", we, 1);
      if (we && prev_we) check("rnd_addr_stable", address, cur_addr);
      if (we && !prev_we) begin
        check("rnd_sb_nonempty", 32'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          check("rnd_addr", address, qa[0]);
          check("rnd_data", data, qd[0]);
          check("rnd_sel", select, qs[0]);
          void'(qa.pop_front()); void'(qd.pop_front()); void'(qs.pop_front());
        end
        cur_addr = address;
        issued++;
        lat = $urandom_range(0, 4);
      end
      mem_write_done = we && (lat == 0);
      if (we && lat > 0) lat--;
      if (!pend && sent < 40 && $urandom_range(0, 1) == 1) begin
        pend = 1'b1;
        ra   = $urandom & 32'hFFFF_FFFC;
        rdd  = $urandom;
        rs   = 4'($urandom_range(1, 15));
      end
      cpu_we = pend; cpu_addr = ra; cpu_data = rdd; cpu_sel = rs;
      #1;
      if (cpu_we && cpu_write_ready) begin
        qa.push_back(ra); qd.push_back(rdd); qs.push_back(rs);
        sent++;
        pend = 1'b0;
      end
      prev_we = we;
      prev_done = mem_write_done;
      tick();
      cyc++;
    end
    cpu_we = 1'b0; mem_write_done = 1'b0;
    check("rnd_issued", 32'(issued), 40);
    check("rnd_sb_left", 32'(qa.size()), 0);
    check("rnd_in_budget", 32'(cyc < 3000), 1);
    tick();
    check("rnd_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
